// File: rtl/vai_pkg.sv
// rtl/vai_pkg.sv - shared constants, state encoding and header helper for the VAI initiator
package vai_pkg;

    localparam int HDR_OP_W   = 4;
    localparam int HDR_ADDR_W = 4;
    localparam int DATA_W     = 8;

    localparam logic [HDR_OP_W-1:0] OP_READ  = 4'h0;
    localparam logic [HDR_OP_W-1:0] OP_WRITE = 4'h1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_HDR  = 3'd1,
        ST_TX_DATA = 3'd2,
        ST_RX_HDR  = 3'd3,
        ST_RX_DATA = 3'd4,
        ST_RX_TRL  = 3'd5,
        ST_RSP     = 3'd6
    } vai_state_e;

    // Header layout: address in the upper nibble, opcode in the lower nibble.
    function automatic logic [DATA_W-1:0] make_header(input logic write,
                                                      input logic [HDR_ADDR_W-1:0] addr);
        return {addr, (write ? OP_WRITE : OP_READ)};
    endfunction

endpackage

// File: rtl/vai_initiator.sv
// rtl/vai_initiator.sv - single-FSM initiator: command -> request frame -> response frame -> result
//
// Ports:
//   Clk_i, Reset_n_i                      clock, asynchronous active-low reset
//   CmdValid_i/CmdWrite_i/CmdAddr_i/CmdData_i, CmdAccept_o   command in
//   Dout_o/DoutValid_o/DoutStart_o/DoutStop_o, DoutAccept_i  request frame out (registered)
//   Din_i/DinValid_i/DinStart_i/DinStop_i, DinAccept_o       response frame in
//   RspValid_o/RspData_o/RspError_o, RspAccept_i             transaction result out
module vai_initiator
    import vai_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  Clk_i,
    input  logic                  Reset_n_i,

    input  logic                  CmdValid_i,
    input  logic                  CmdWrite_i,
    input  logic [HDR_ADDR_W-1:0] CmdAddr_i,
    input  logic [DATA_W-1:0]     CmdData_i,
    output logic                  CmdAccept_o,

    output logic [DATA_W-1:0]     Dout_o,
    output logic                  DoutValid_o,
    output logic                  DoutStart_o,
    output logic                  DoutStop_o,
    input  logic                  DoutAccept_i,

    input  logic [DATA_W-1:0]     Din_i,
    input  logic                  DinValid_i,
    input  logic                  DinStart_i,
    input  logic                  DinStop_i,
    output logic                  DinAccept_o,

    output logic                  RspValid_o,
    output logic [DATA_W-1:0]     RspData_o,
    output logic                  RspError_o,
    input  logic                  RspAccept_i
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    vai_state_e              state_q, state_d;
    logic                    cmd_write_q, cmd_write_d;
    logic [HDR_ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]       cmd_data_q, cmd_data_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [7:0]              idle_cnt_q, idle_cnt_d;

    logic [DATA_W-1:0]       dout_q, dout_d;
    logic                    dout_valid_q, dout_valid_d;
    logic                    dout_start_q, dout_start_d;
    logic                    dout_stop_q, dout_stop_d;

    logic                    in_rx;
    logic [DATA_W-1:0]       sent_hdr;
    logic [DATA_W-1:0]       next_hdr;

    assign in_rx    = (state_q == ST_RX_HDR) || (state_q == ST_RX_DATA) || (state_q == ST_RX_TRL);
    assign sent_hdr = make_header(cmd_write_q, cmd_addr_q);

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        idle_cnt_d  = idle_cnt_q;

        if (in_rx) begin
            idle_cnt_d = DinValid_i ? 8'd0 : idle_cnt_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (CmdValid_i) begin
                    cmd_write_d = CmdWrite_i;
                    cmd_addr_d  = CmdAddr_i;
                    cmd_data_d  = CmdData_i;
                    state_d     = ST_TX_HDR;
                end
            end
            ST_TX_HDR: begin
                if (DoutAccept_i) begin
                    state_d = cmd_write_q ? ST_TX_DATA : ST_RX_HDR;
                end
            end
            ST_TX_DATA: begin
                if (DoutAccept_i) begin
                    state_d = ST_RX_HDR;
                end
            end
            ST_RX_HDR: begin
                // Beats before a Start marker are line noise and are dropped.
                if (DinValid_i && DinStart_i) begin
                    if ((Din_i != sent_hdr) || DinStop_i) begin
                        err_d = 1'b1;
                    end
                    state_d = cmd_write_q ? ST_RX_TRL : ST_RX_DATA;
                end
            end
            ST_RX_DATA: begin
                if (DinValid_i) begin
                    rdata_d = Din_i;
                    if (DinStop_i) begin
                        err_d   = 1'b1;
                        state_d = ST_RSP;
                    end else begin
                        state_d = ST_RX_TRL;
                    end
                end
            end
            ST_RX_TRL: begin
                if (DinValid_i) begin
                    if (DinStop_i) begin
                        err_d   = err_q | Din_i[0];
                        state_d = ST_RSP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RSP: begin
                if (RspAccept_i) begin
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A silent responder aborts the transaction with an error result.
        if (in_rx && !DinValid_i && ((idle_cnt_q + 8'd1) == TIMEOUT_CNT)) begin
            err_d   = 1'b1;
            state_d = ST_RSP;
        end

        if (state_d == ST_RSP) begin
            idle_cnt_d = 8'd0;
        end
    end

    // Request outputs are computed from the next state so they appear as
    // flops; while a beat is stalled the next state and command are unchanged,
    // which keeps the beat stable.
    assign next_hdr = make_header(cmd_write_d, cmd_addr_d);

    always_comb begin
        dout_valid_d = 1'b0;
        dout_start_d = 1'b0;
        dout_stop_d  = 1'b0;
        dout_d       = '0;
        if (state_d == ST_TX_HDR) begin
            dout_valid_d = 1'b1;
            dout_start_d = 1'b1;
            dout_stop_d  = !cmd_write_d;
            dout_d       = next_hdr;
        end else if (state_d == ST_TX_DATA) begin
            dout_valid_d = 1'b1;
            dout_stop_d  = 1'b1;
            dout_d       = cmd_data_d;
        end
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q      <= ST_IDLE;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
            idle_cnt_q   <= 8'd0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_start_q <= 1'b0;
            dout_stop_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_data_q   <= cmd_data_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            idle_cnt_q   <= idle_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_start_q <= dout_start_d;
            dout_stop_q  <= dout_stop_d;
        end
    end

    assign CmdAccept_o = (state_q == ST_IDLE);
    assign DinAccept_o = in_rx;
    assign RspValid_o  = (state_q == ST_RSP);
    assign RspData_o   = rdata_q;
    assign RspError_o  = err_q;
    assign Dout_o      = dout_q;
    assign DoutValid_o = dout_valid_q;
    assign DoutStart_o = dout_start_q;
    assign DoutStop_o  = dout_stop_q;

endmodule

// File: tb/tb_vai_initiator.sv
// tb/tb_vai_initiator.sv - scoreboard bench for vai_initiator with a frame-level reference model
module tb_vai_initiator;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       Reset_n_i = 1'b0;
    logic       CmdValid_i = 1'b0;
    logic       CmdWrite_i = 1'b0;
    logic [3:0] CmdAddr_i = '0;
    logic [7:0] CmdData_i = '0;
    logic       CmdAccept_o;
    logic [7:0] Dout_o;
    logic       DoutValid_o, DoutStart_o, DoutStop_o;
    logic       DoutAccept_i = 1'b0;
    logic [7:0] Din_i = '0;
    logic       DinValid_i = 1'b0, DinStart_i = 1'b0, DinStop_i = 1'b0;
    logic       DinAccept_o;
    logic       RspValid_o;
    logic [7:0] RspData_o;
    logic       RspError_o;
    logic       RspAccept_i = 1'b0;

    vai_initiator #(.TIMEOUT(TO)) dut (
        .Clk_i(clk), .Reset_n_i(Reset_n_i),
        .CmdValid_i(CmdValid_i), .CmdWrite_i(CmdWrite_i), .CmdAddr_i(CmdAddr_i),
        .CmdData_i(CmdData_i), .CmdAccept_o(CmdAccept_o),
        .Dout_o(Dout_o), .DoutValid_o(DoutValid_o), .DoutStart_o(DoutStart_o),
        .DoutStop_o(DoutStop_o), .DoutAccept_i(DoutAccept_i),
        .Din_i(Din_i), .DinValid_i(DinValid_i), .DinStart_i(DinStart_i),
        .DinStop_i(DinStop_i), .DinAccept_o(DinAccept_o),
        .RspValid_o(RspValid_o), .RspData_o(RspData_o), .RspError_o(RspError_o),
        .RspAccept_i(RspAccept_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       p;
        logic [7:0] gap;
    } beat_t;

    beat_t      cur_beats[$];
    logic [9:0] req_q[$];   // {data, start, stop}
    logic [8:0] rsp_q[$];   // {data, error}

    int checks = 0;
    int fails  = 0;

    int sink_mode = 0;      // 0: stimulus drives accepts, 1: random, 2: stall counters
    int dout_stall = 0;
    int rsp_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: walk the response beats and apply the protocol rules.
    function automatic logic [8:0] model(input bit wr, input logic [3:0] a);
        logic [7:0] hdr;
        int         ph;
        bit         err;
        bit         done;
        logic [7:0] rd;
        hdr  = {a, 3'b000, wr};
        ph   = 0;
        err  = 0;
        done = 0;
        rd   = 8'h00;
        for (int i = 0; i < cur_beats.size(); i++) begin
            if (int'(cur_beats[i].gap) >= TO) begin
                err = 1; done = 1; break;
            end
            if (ph == 0) begin
                if (cur_beats[i].s) begin
                    if (cur_beats[i].d != hdr || cur_beats[i].p) err = 1;
                    ph = wr ? 2 : 1;
                end
            end else if (ph == 1) begin
                rd = cur_beats[i].d;
                if (cur_beats[i].p) begin err = 1; done = 1; break; end
                ph = 2;
            end else begin
                if (cur_beats[i].p) begin
                    err = err | cur_beats[i].d[0]; done = 1; break;
                end
                err = 1;
            end
        end
        if (!done) err = 1;
        return {rd, err};
    endfunction

    // Accept-side sink.
    always @(posedge clk) begin
        #1;
        if (sink_mode == 1) begin
            DoutAccept_i = ($urandom_range(0, 2) != 0);
            RspAccept_i  = ($urandom_range(0, 2) != 0);
        end else if (sink_mode == 2) begin
            DoutAccept_i = !(DoutValid_o && dout_stall > 0);
            if (DoutValid_o && dout_stall > 0) dout_stall--;
            RspAccept_i = !(RspValid_o && rsp_stall > 0);
            if (RspValid_o && rsp_stall > 0) rsp_stall--;
        end
    end

    // Monitor: stability of stalled outputs and scoreboard pops on handshakes.
    logic       p_dv = 0, p_da = 0, p_ds = 0, p_dp = 0;
    logic [7:0] p_d = 0;
    logic       p_rv = 0, p_ra = 0, p_re = 0;
    logic [7:0] p_rd = 0;

    always @(negedge clk) begin
        if (Reset_n_i) begin
            if (p_dv && !p_da)
                chk("dout_hold", {Dout_o, DoutValid_o, DoutStart_o, DoutStop_o}, {p_d, 1'b1, p_ds, p_dp});
            if (p_rv && !p_ra)
                chk("rsp_hold", {RspValid_o, RspData_o, RspError_o}, {1'b1, p_rd, p_re});
            if (DoutValid_o && DoutAccept_i) begin
                if (req_q.size() == 0) chk("dout_unexpected", 1, 0);
                else chk("dout_beat", {Dout_o, DoutStart_o, DoutStop_o}, req_q.pop_front());
            end
            if (RspValid_o && RspAccept_i) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_result", {RspData_o, RspError_o}, rsp_q.pop_front());
            end
            p_dv = DoutValid_o; p_da = DoutAccept_i; p_d = Dout_o; p_ds = DoutStart_o; p_dp = DoutStop_o;
            p_rv = RspValid_o;  p_ra = RspAccept_i;  p_rd = RspData_o; p_re = RspError_o;
        end else begin
            p_dv = 0; p_rv = 0;
        end
    end

    task automatic issue(input bit wr, input logic [3:0] a, input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        while (!CmdAccept_o && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) chk("cmd_accept_wait", CmdAccept_o, 1);
        CmdValid_i = 1; CmdWrite_i = wr; CmdAddr_i = a; CmdData_i = d;
        @(posedge clk); #1;
        CmdValid_i = 0;
    endtask

    task automatic run_txn(input bit wr, input logic [3:0] a, input logic [7:0] d);
        logic [7:0] hdr;
        int         n;
        hdr = {a, 3'b000, wr};
        if (wr) begin
            req_q.push_back({hdr, 1'b1, 1'b0});
            req_q.push_back({d, 1'b0, 1'b1});
        end else begin
            req_q.push_back({hdr, 1'b1, 1'b1});
        end
        rsp_q.push_back(model(wr, a));
        issue(wr, a, d);
        n = 0;
        @(negedge clk);
        while (!DinAccept_o && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("rx_start_wait", DinAccept_o, 1);
        if (cur_beats.size() == 0) begin
            n = 1;
            while (!RspValid_o && n < 50) begin @(negedge clk); n++; end
            chk("timeout_latency", n, TO + 1);
        end
        for (int i = 0; i < cur_beats.size(); i++) begin
            int g;
            g = (i == 0) ? int'(cur_beats[i].gap) - 1 : int'(cur_beats[i].gap);
            repeat (g) begin @(posedge clk); #1; DinValid_i = 0; end
            @(posedge clk); #1;
            DinValid_i = 1; Din_i = cur_beats[i].d;
            DinStart_i = cur_beats[i].s; DinStop_i = cur_beats[i].p;
            @(negedge clk);
            if (!DinAccept_o) break;
        end
        @(posedge clk); #1;
        DinValid_i = 0; DinStart_i = 0; DinStop_i = 0;
        n = 0;
        @(negedge clk);
        while (!(CmdAccept_o && rsp_q.size() == 0) && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) chk("txn_complete_wait", rsp_q.size(), 0);
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic s, input logic p, input int gap);
        beat_t b;
        b.d = d; b.s = s; b.p = p; b.gap = 8'(gap);
        return b;
    endfunction

    task automatic gen_random(input bit wr, input logic [3:0] a);
        int         r;
        logic [7:0] hdr;
        hdr = {a, 3'b000, wr};
        r = $urandom_range(0, 9);
        cur_beats.delete();
        if (r == 0)
            cur_beats.push_back(mk(8'($urandom), 1'b0, 1'($urandom), $urandom_range(1, 2)));
        cur_beats.push_back(mk((r == 1) ? (hdr ^ (8'h01 << $urandom_range(0, 7))) : hdr, 1'b1, r == 2,
                               (r == 0) ? $urandom_range(0, 2) : $urandom_range(1, 3)));
        if (!wr) cur_beats.push_back(mk(8'($urandom), 1'b0, r == 3, $urandom_range(0, 2)));
        cur_beats.push_back(mk((r == 4) ? 8'h01 : 8'h00, 1'b0, r != 5,
                               (r == 6) ? $urandom_range(TO, TO + 2) : $urandom_range(0, 2)));
        if (r == 5) cur_beats.push_back(mk(8'h00, 1'b0, 1'b1, $urandom_range(0, 2)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, asynchronously and after release.
        #3;
        chk("rst_cmd_accept", CmdAccept_o, 1);
        chk("rst_dout", {Dout_o, DoutValid_o, DoutStart_o, DoutStop_o}, 0);
        chk("rst_din_accept", DinAccept_o, 0);
        chk("rst_rsp", {RspValid_o, RspData_o, RspError_o}, 0);
        repeat (2) @(posedge clk);
        #1 Reset_n_i = 1;
        @(negedge clk);
        chk("post_rst_cmd_accept", CmdAccept_o, 1);
        chk("post_rst_dout_valid", DoutValid_o, 0);

        // Reset while the write data beat is stalled.
        sink_mode = 0; DoutAccept_i = 1; RspAccept_i = 0;
        req_q.push_back({8'h51, 1'b1, 1'b0});
        issue(1'b1, 4'h5, 8'h77);
        begin
            int n = 0;
            @(negedge clk);
            while (!(DoutValid_o && DoutStart_o) && n < 20) begin @(negedge clk); n++; end
        end
        @(posedge clk); #1 DoutAccept_i = 0;
        @(negedge clk);
        chk("tx_data_beat", {Dout_o, DoutValid_o, DoutStart_o, DoutStop_o}, {8'h77, 3'b101});
        #1 Reset_n_i = 0;
        #1;
        chk("mid_rst_dout", {Dout_o, DoutValid_o, DoutStart_o, DoutStop_o}, 0);
        chk("mid_rst_accepts", {CmdAccept_o, DinAccept_o}, 2'b10);
        chk("mid_rst_rsp", {RspValid_o, RspData_o, RspError_o}, 0);
        chk("mid_rst_pending", req_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 Reset_n_i = 1;

        // Read addr 3, clean response.
        sink_mode = 2; dout_stall = 0; rsp_stall = 0;
        cur_beats.delete();
        cur_beats.push_back(mk(8'h30, 1, 0, 1));
        cur_beats.push_back(mk(8'hA5, 0, 0, 0));
        cur_beats.push_back(mk(8'h00, 0, 1, 0));
        run_txn(1'b0, 4'h3, 8'h00);

        // Write addr 2 with the header stalled for 3 cycles.
        dout_stall = 3;
        cur_beats.delete();
        cur_beats.push_back(mk(8'h21, 1, 0, 1));
        cur_beats.push_back(mk(8'h00, 0, 1, 0));
        run_txn(1'b1, 4'h2, 8'h5C);

        // Read with a mismatching response header.
        cur_beats.delete();
        cur_beats.push_back(mk(8'h31, 1, 0, 1));
        cur_beats.push_back(mk(8'h44, 0, 0, 0));
        cur_beats.push_back(mk(8'h00, 0, 1, 0));
        run_txn(1'b0, 4'h3, 8'h00);

        // Read with a silent responder.
        cur_beats.delete();
        run_txn(1'b0, 4'h1, 8'h00);

        // Write whose trailer flags an error; result held for 5 cycles.
        rsp_stall = 5;
        cur_beats.delete();
        cur_beats.push_back(mk(8'h61, 1, 0, 2));
        cur_beats.push_back(mk(8'h01, 0, 1, 1));
        run_txn(1'b1, 4'h6, 8'h9A);

        // Randomized traffic with random back-pressure.
        sink_mode = 1;
        for (int t = 0; t < 60; t++) begin
            bit         wr;
            logic [3:0] a;
            wr = 1'($urandom);
            a  = 4'($urandom);
            gen_random(wr, a);
            run_txn(wr, a, 8'($urandom));
        end

        repeat (5) @(posedge clk);
        chk("req_q_drained", req_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
